// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd6
    } state_t;

    // Memory address mux select
    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    // PC source select
    localparam logic PC_PLUS4  = 1'b0;
    localparam logic PC_TARGET = 1'b1;

    // States that hold a memory request open and wait on mem_ready
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Shared memory-port handshake between the sequencer and the memory.
// Latency: n/a (wires only).
// Backpressure: memory stalls the requester by holding mem_ready low.
interface core_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic mem_sel_data;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel_data,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel_data,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of an open memory request and flags the timeout.
// Latency: expired is combinational in the cycle whose stall reaches the limit.
// Backpressure: none; mem_ready in the limit cycle suppresses expiry.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic [CW:0]   wait_next;

    // Clear outside the wait states and on completion, otherwise count stalls
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        wait_next  = {1'b0, wait_cnt_q} + (CW+1)'(1);
        if (clear || mem_ready) begin
            wait_cnt_d = '0;
        end else if (count_en) begin
            wait_cnt_d = wait_next[CW-1:0];
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // This stall cycle brings the count to the limit; a zero limit never expires
    assign expired = (MEM_TIMEOUT != 0) && count_en && !mem_ready &&
                     (wait_next == (CW+1)'(MEM_TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback plus counters.
// Latency: 4 cycles ALU/branch, 5 cycles load/store, +1 per memory wait cycle.
// Backpressure: mem_ready low holds FETCH/MEM; a stall reaching MEM_TIMEOUT faults.
module core_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dec_mem,
    input  logic             dec_mem_read,
    input  logic [1:0]       dec_wb,
    input  logic             dec_branch,
    input  logic             branch_taken,
    core_sequencer_if.master mem,
    output logic             ir_we,
    output logic             ld_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel_target,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    logic mem_req;
    logic mem_we;
    logic mem_sel_data;
    logic wait_active;
    logic timer_expired;

    assign wait_active = is_mem_wait(state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (!wait_active),
        .count_en  (wait_active),
        .mem_ready (mem.mem_ready),
        .expired   (timer_expired)
    );

    // Next-state and strobe decode; request signals are pure functions of state
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel_data  = ADDR_PC;
        ir_we         = 1'b0;
        ld_we         = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel_target = PC_PLUS4;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req      = 1'b1;
                mem_sel_data = ADDR_PC;
                if (timer_expired) begin
                    state_d = FAULT;
                end else if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = dec_mem ? MEM : WRITEBACK;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_we       = !dec_mem_read;
                mem_sel_data = ADDR_ALU;
                if (timer_expired) begin
                    state_d = FAULT;
                end else if (mem.mem_ready) begin
                    ld_we   = dec_mem_read;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                pc_we         = 1'b1;
                rf_we         = (dec_wb != 2'd0);
                pc_sel_target = (dec_branch && branch_taken) ? PC_TARGET : PC_PLUS4;
                state_d       = run ? FETCH : IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cycle counter runs while an instruction is in flight; instret bumps on retire
    always_comb begin
        cycle_count_d = cycle_count_q;
        instret_d     = instret_q;
        if ((state_q != IDLE) && (state_q != FAULT)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (state_q == WRITEBACK) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cycle_count_q <= '0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            instret_q     <= instret_d;
        end
    end

    assign mem.mem_req      = mem_req;
    assign mem.mem_we       = mem_we;
    assign mem.mem_sel_data = mem_sel_data;
    assign fault            = (state_q == FAULT);
    assign cycle_count      = cycle_count_q;
    assign instret          = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-instruction records checked at retire.
// Latency: n/a.
// Backpressure: memory responder inserts a programmable number of wait cycles.
module tb_core_sequencer;
    import core_pkg::*;

    localparam int CW   = 4;
    localparam int TMO  = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          dec_mem = 1'b0;
    logic          dec_mem_read = 1'b0;
    logic [1:0]    dec_wb = 2'd0;
    logic          dec_branch = 1'b0;
    logic          branch_taken = 1'b0;
    logic          ir_we, ld_we, rf_we, pc_we, pc_sel_target, fault;
    logic [CW-1:0] cycle_count, instret;

    core_sequencer_if mem ();

    core_sequencer #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .dec_mem       (dec_mem),
        .dec_mem_read  (dec_mem_read),
        .dec_wb        (dec_wb),
        .dec_branch    (dec_branch),
        .branch_taken  (branch_taken),
        .mem           (mem.master),
        .ir_we         (ir_we),
        .ld_we         (ld_we),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel_target (pc_sel_target),
        .fault         (fault),
        .cycle_count   (cycle_count),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int dreq;
        int ld;
        int st;
        int rf;
        int pcs;
    } rec_t;

    rec_t exp_q[$];
    rec_t e_m;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory responder: ready after fetch_wait / data_wait stalled cycles
    int fetch_wait = 0;
    int data_wait  = 0;
    int wcnt       = 0;
    initial begin
        mem.mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem.mem_req && !rst) begin
                mem.mem_ready = (wcnt == (mem.mem_sel_data ? data_wait : fetch_wait));
                wcnt++;
            end else begin
                mem.mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: accumulate per-instruction observations, compare on retire
    int lat = 0, dreq = 0, ld = 0, st = 0, ir = 0, stray = 0, busy = 0, ret = 0;
    always @(negedge clk) begin
        if (rst) begin
            lat = 0; dreq = 0; ld = 0; st = 0; ir = 0; stray = 0; busy = 0; ret = 0;
        end else begin
            if (!fault && (lat > 0 || (mem.mem_req && !mem.mem_sel_data))) begin
                lat++;
                busy++;
            end
            if (mem.mem_req && mem.mem_sel_data) begin
                dreq++;
                if (mem.mem_we) st = 1;
            end
            if (ld_we) ld++;
            if (ir_we) ir++;
            if (rf_we && !pc_we) stray++;
            if (pc_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e_m = exp_q.pop_front();
                    check("latency", lat, e_m.lat);
                    check("data_req_cycles", dreq, e_m.dreq);
                    check("ld_we_pulses", ld, e_m.ld);
                    check("store_we", st, e_m.st);
                    check("rf_we", rf_we, e_m.rf);
                    check("pc_sel_target", pc_sel_target, e_m.pcs);
                    check("ir_we_pulses", ir, 1);
                    check("rf_we_outside_wb", stray, 0);
                    check("cycle_count_at_wb", cycle_count, (busy - 1) & MASK);
                    check("instret_at_wb", instret, ret & MASK);
                end
                ret++;
                lat = 0; dreq = 0; ld = 0; st = 0; ir = 0; stray = 0;
            end
        end
    end

    // All outputs packed; zero under reset
    function automatic logic [31:0] all_outs();
        return {15'd0, mem.mem_req, mem.mem_we, mem.mem_sel_data, ir_we, ld_we, rf_we,
                pc_we, pc_sel_target, fault, cycle_count, instret};
    endfunction

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
    endtask

    // Issue one instruction starting from IDLE or right after a WB, wait for retire
    task automatic issue(input int fw, input int dw, input bit m, input bit rd,
                         input logic [1:0] wb, input bit br, input bit tk, input bit drop);
        rec_t e;
        int   r0;
        fetch_wait   = fw;
        data_wait    = dw;
        dec_mem      = m;
        dec_mem_read = rd;
        dec_wb       = wb;
        dec_branch   = br;
        branch_taken = tk;
        run          = 1'b1;
        e.lat  = 4 + fw + (m ? 1 + dw : 0);
        e.dreq = m ? 1 + dw : 0;
        e.ld   = (m && rd) ? 1 : 0;
        e.st   = (m && !rd) ? 1 : 0;
        e.rf   = (wb != 2'd0) ? 1 : 0;
        e.pcs  = (br && tk) ? 1 : 0;
        exp_q.push_back(e);
        r0 = ret;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); #1;
            if (drop && k == 3 + fw) run = 1'b0;
            if (ret != r0) break;
        end
        if (ret == r0) check("retire_timeout", 0, 1);
    endtask

    initial begin
        int nreq;
        bit seen;

        #2;
        do_reset();

        // Two ALU ops back to back: 4 cycles each, no bubble
        issue(0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        issue(0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        // Load with 3 data wait cycles: 8 cycles, 4 request cycles
        issue(0, 3, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        // Branch taken / not taken
        issue(0, 0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        issue(0, 0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        // Store with fetch and data waits
        issue(1, 1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        // Fetch ready on the 4th stalled cycle: limit cycle completes, no fault
        issue(3, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("no_fault_at_limit_ready", fault, 0);
        // Store with run dropped in EXECUTE: completes, then IDLE
        issue(0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("idle_after_drop_req", mem.mem_req, 0);
        end
        check("instret_after_drop", instret, ret & MASK);
        check("cycle_count_frozen_idle", cycle_count, busy & MASK);

        // Counter wrap: 17 ALU ops with 4-bit counters
        do_reset();
        for (int i = 0; i < 17; i++) issue(0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, i == 16);
        @(negedge clk); #1;
        check("instret_wrap", instret, 1);
        check("cycle_count_wrap", cycle_count, 4);

        // Fetch timeout: memory never answers
        fetch_wait = 99;
        dec_mem    = 1'b0;
        dec_wb     = 2'd1;
        run        = 1'b1;
        nreq       = 0;
        seen       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (fault) begin
                seen = 1'b1;
                break;
            end
            if (mem.mem_req) nreq++;
        end
        check("fault_seen", seen, 1);
        check("fault_wait_cycles", nreq, TMO);
        check("fault_req_low", mem.mem_req, 0);
        check("fault_cycle_count", cycle_count, 8);
        run = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("fault_sticky", fault, 1);
        check("fault_cycle_frozen", cycle_count, 8);

        // Async reset in the middle of a data transfer
        do_reset();
        fetch_wait   = 0;
        data_wait    = 99;
        dec_mem      = 1'b1;
        dec_mem_read = 1'b1;
        run          = 1'b1;
        seen         = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (mem.mem_req && mem.mem_sel_data) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_mem", seen, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        check("async_reset_state", dut.state_q, IDLE);
        run = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_reset_idle", {mem.mem_req, instret, cycle_count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder and the ALU/register-file datapath. It owns the single shared memory port handshake, the IR/PC/register-file write strobes, a memory-wait timeout, and the cycle/retired-instruction counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle and instret counters
- MEM_TIMEOUT, 255, max wait cycles for mem_ready (0 disables timeout)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; enables starting a new instruction
- dec_mem  in  1  decoded instruction is load/store
- dec_mem_read  in  1  decoded memory op is a load (0 = store)
- dec_wb  in  2  decoded writeback select; 0 = no register write
- dec_branch  in  1  decoded instruction may redirect PC (branch/jump)
- branch_taken  in  1  datapath comparison result, valid in EXECUTE and WRITEBACK
- mem_ready  in  1  memory completes the current transfer this cycle
- mem_req  out  1  memory transfer request
- mem_we  out  1  store when 1, read when 0
- mem_sel_data  out  1  address mux: 0 = PC (fetch), 1 = ALU result (data)
- ir_we  out  1  capture fetched word into IR
- ld_we  out  1  capture load data into the load-data register
- rf_we  out  1  register-file write enable
- pc_we  out  1  PC update enable
- pc_sel_target  out  1  PC source: 0 = PC+4, 1 = ALU target
- fault  out  1  memory timeout; sticky until reset
- cycle_count  out  CNT_W  cycles spent outside IDLE/FAULT
- instret  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT. Reset state is IDLE.
- IDLE:
  - run=1 → FETCH.
  - Otherwise hold; no strobes.
- FETCH:
  - mem_req=1, mem_we=0, mem_sel_data=0.
  - On mem_ready: ir_we=1 → DECODE.
- DECODE: one cycle; register operands read → EXECUTE.
- EXECUTE: one cycle.
  - dec_mem=1 → MEM.
  - Otherwise → WRITEBACK.
- MEM:
  - mem_req=1, mem_we=!dec_mem_read, mem_sel_data=1.
  - On mem_ready: ld_we=dec_mem_read → WRITEBACK.
- WRITEBACK:
  - pc_we=1.
  - rf_we=(dec_wb!=0).
  - pc_sel_target=dec_branch & branch_taken.
  - instret+1.
  - Next state: run=1 → FETCH, else → IDLE.
- FAULT: all strobes and mem_req 0; held until rst.
- Output decode:
  - mem_req, mem_we, mem_sel_data, pc_we and pc_sel_target are Moore (decoded from state).
  - ir_we and ld_we are Mealy, qualified by mem_ready.
  - rf_we is a function of state and dec_wb.
- Timeout:
  - wait counter clears on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle in FETCH/MEM with mem_ready=0.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0 → FAULT next cycle.
  - mem_ready in the same cycle as the limit wins: the transfer completes, no fault.
- Counters:
  - cycle_count increments in every state except IDLE/FAULT.
  - Both counters wrap modulo 2^CNT_W.
- run deasserted mid-instruction: the instruction completes through WRITEBACK, then IDLE.
- dec_* inputs are ignored outside EXECUTE/MEM/WRITEBACK. The IR holds them stable from DECODE through WRITEBACK.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Reset values: state IDLE; every output 0; counters 0; wait counter 0.
- rst asserted mid-transfer drops mem_req asynchronously. No write strobes fire.
- Handshake rules:
  - mem_req, mem_we and the address select stay stable from request until the mem_ready cycle.
  - The transfer completes in that cycle.
  - mem_req is low the following cycle, since the state has left FETCH/MEM.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - ALU/branch/jump/LUI: 4 cycles (F, D, E, WB).
  - Load/store: 5 cycles (F, D, E, M, WB).
  - Each wait cycle adds 1.
- Back-to-back: with run=1, WRITEBACK is followed directly by FETCH with no bubble.

## Structure
- Shared package core_pkg holds:
  - the state enum (IDLE..FAULT);
  - the address-select constants ADDR_PC=0, ADDR_ALU=1;
  - the PC-source constants PC_PLUS4=0, PC_TARGET=1.
- Sub-module mem_wait_timer: wait counter plus limit compare.
  - Inputs: clear, count enable, mem_ready.
  - Output: expired.
  - Parameter: MEM_TIMEOUT.
- The FSM and both counters stay in core_sequencer.

## Test plan
- Reset, run=1, ALU op (dec_mem=0, dec_wb=2), mem_ready always 1:
  - states IDLE→F→D→E→WB→F;
  - rf_we=1 only in WB;
  - instret=1 after 4 cycles.
- Load (dec_mem=1, dec_mem_read=1), data-phase mem_ready delayed 3 cycles:
  - mem_req high 4 cycles with mem_sel_data=1, mem_we=0;
  - ld_we pulses once on the ready cycle;
  - total 8 cycles.
- Taken branch (dec_branch=1, branch_taken=1, dec_wb=0):
  - WB gives pc_we=1, pc_sel_target=1, rf_we=0.
  - The same case with branch_taken=0 gives pc_sel_target=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH:
  - FAULT entered after 4 wait cycles, fault=1, mem_req=0;
  - cycle_count then frozen.
  - Variant: mem_ready=1 on the 4th wait cycle completes the fetch with no fault.
- Boundary events:
  - run dropped during EXECUTE of a store: store completes (mem_we=1), WB, then IDLE.
  - rst pulsed mid-MEM: all outputs 0 immediately, state IDLE.
- CNT_W=4: 17 retired ALU instructions → instret=1 (wraps).
